// File: rtl/ibus_pkg.sv
// Shared types and helpers for the iBus32 initiator: access sizes, FSM states,
// lane-mask and misalignment functions.
package ibus_pkg;

  localparam int WA = 15;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_sz_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_W  = 2'd1,
    SPLIT = 2'd2,
    RD_W2 = 2'd3
  } state_t;

  // Reserved size 3 behaves as a word access.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'd0:    m = 4'h1;
      2'd1:    m = 4'h3;
      default: m = 4'hF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic r;
    case (sz)
      2'd0:    r = 1'b0;
      2'd1:    r = (off == 2'd3);
      default: r = (off != 2'd0);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ibus32_if.sv
// iBus32 word bus between the initiator and the 32K x 32 single-port RAM.
interface ibus32_if;
  import ibus_pkg::*;

  logic          we;
  logic [3:0]    bmsk;
  logic [WA-1:0] ai;
  logic [31:0]   vi;
  logic [31:0]   vo;

  modport master (output we, bmsk, ai, vi, input vo);
  modport slave  (input we, bmsk, ai, vi, output vo);

endinterface

// File: rtl/ibus_lane_align.sv
// Combinational lane steering: store-lane placement across two words and
// right-aligned, zero-extended extraction of load data from a word pair.
module ibus_lane_align
  import ibus_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  sz,
  input  logic [31:0] wdata,
  input  logic [31:0] vo_lo,
  input  logic [31:0] vo_hi,
  output logic [3:0]  bmsk_lo,
  output logic [3:0]  bmsk_hi,
  output logic [31:0] vi_lo,
  output logic [31:0] vi_hi,
  output logic [31:0] rdata
);

  logic [3:0]  lm_s;
  logic [6:0]  mask7_s;
  logic [63:0] pair_s;
  logic [31:0] byte_mask_s;
  logic [2:0]  rem_s;

  // Lane placement for the first and (if any) spill-over word, plus load extraction.
  always_comb begin
    lm_s        = lane_mask(sz);
    mask7_s     = {3'b000, lm_s} << off;
    bmsk_lo     = mask7_s[3:0];
    bmsk_hi     = {1'b0, mask7_s[6:4]};
    vi_lo       = wdata << {off, 3'b000};
    rem_s       = 3'd4 - {1'b0, off};
    vi_hi       = (off == 2'd0) ? 32'h0 : (wdata >> {rem_s, 3'b000});
    pair_s      = {vo_hi, vo_lo} >> {off, 3'b000};
    byte_mask_s = {{8{lm_s[3]}}, {8{lm_s[2]}}, {8{lm_s[1]}}, {8{lm_s[0]}}};
    rdata       = pair_s[31:0] & byte_mask_s;
  end

endmodule

// File: rtl/ibus32_master.sv
// iBus32 initiator: byte/half/word load-store to word accesses with lane masks.
// Define IBUS_UNALIGNED_EN to split misaligned accesses; otherwise they return err.
module ibus32_master
  import ibus_pkg::*;
#(
  parameter int AW = 17,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  output logic          rdy,
  input  logic          we,
  input  logic [1:0]    sz,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  ibus32_if.master      bus
);

  state_t        state_r;
  logic [WA-1:0] a_r;
  logic [1:0]    off_r;
  logic [1:0]    sz_r;
`ifdef IBUS_UNALIGNED_EN
  logic          we_r;
  logic [31:0]   wdata_r;
  logic [31:0]   lo_r;
`endif

  logic          idle_s, accept_s, mis_s;
  logic [1:0]    al_off_s, al_sz_s;
  logic [31:0]   al_wdata_s, vo_lo_s, vo_hi_s, ext_s, vi_lo_s, vi_hi_s;
  logic [3:0]    bmsk_lo_s, bmsk_hi_s;
  logic          bus_we_s;
  logic [3:0]    bus_bmsk_s;
  logic [WA-1:0] bus_ai_s;
  logic [31:0]   bus_vi_s;

  assign idle_s   = (state_r == IDLE);
  assign rdy      = idle_s;
  assign accept_s = req & idle_s;
  assign mis_s    = misaligned(sz, addr[1:0]);

  // Aligner follows the live request in IDLE and the captured one afterwards.
  always_comb begin
    if (idle_s) begin
      al_off_s = addr[1:0];
      al_sz_s  = sz;
    end else begin
      al_off_s = off_r;
      al_sz_s  = sz_r;
    end
`ifdef IBUS_UNALIGNED_EN
    al_wdata_s = idle_s ? wdata : wdata_r;
    vo_lo_s    = (state_r == RD_W2) ? lo_r : bus.vo;
    vo_hi_s    = (state_r == RD_W2) ? bus.vo : 32'h0;
`else
    al_wdata_s = wdata;
    vo_lo_s    = bus.vo;
    vo_hi_s    = 32'h0;
`endif
  end

  ibus_lane_align u_align (
    .off     (al_off_s),
    .sz      (al_sz_s),
    .wdata   (al_wdata_s),
    .vo_lo   (vo_lo_s),
    .vo_hi   (vo_hi_s),
    .bmsk_lo (bmsk_lo_s),
    .bmsk_hi (bmsk_hi_s),
    .vi_lo   (vi_lo_s),
    .vi_hi   (vi_hi_s),
    .rdata   (ext_s)
  );

`ifndef IBUS_UNALIGNED_EN
  logic unused_split_s;
  assign unused_split_s = ^{bmsk_hi_s, vi_hi_s};
`endif

  // Bus drive: IDLE passes the request straight through so the RAM samples it at accept.
  always_comb begin
    bus_we_s   = 1'b0;
    bus_bmsk_s = 4'h0;
    bus_ai_s   = {WA{1'b0}};
    bus_vi_s   = 32'h0;
    if (!rst_n) begin
      bus_we_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus_ai_s = addr[AW-1:2];
          bus_vi_s = vi_lo_s;
          if (req) begin
`ifdef IBUS_UNALIGNED_EN
            bus_we_s = we;
`else
            bus_we_s = we & ~mis_s;
`endif
          end else begin
            bus_we_s = 1'b0;
          end
          bus_bmsk_s = bus_we_s ? bmsk_lo_s : 4'h0;
        end
        RD_W: bus_ai_s = a_r;
`ifdef IBUS_UNALIGNED_EN
        SPLIT: begin
          bus_ai_s   = a_r + 15'd1;
          bus_we_s   = we_r;
          bus_bmsk_s = we_r ? bmsk_hi_s : 4'h0;
          bus_vi_s   = vi_hi_s;
        end
        RD_W2: bus_ai_s = a_r + 15'd1;
`endif
        default: bus_ai_s = {WA{1'b0}};
      endcase
    end
  end

  assign bus.we   = bus_we_s;
  assign bus.bmsk = bus_bmsk_s;
  assign bus.ai   = bus_ai_s;
  assign bus.vi   = bus_vi_s;

  // Transaction FSM with registered ack/err/rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WA{1'b0}};
      off_r   <= 2'd0;
      sz_r    <= 2'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= {DW{1'b0}};
`ifdef IBUS_UNALIGNED_EN
      we_r    <= 1'b0;
      wdata_r <= 32'h0;
      lo_r    <= 32'h0;
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= addr[AW-1:2];
            off_r <= addr[1:0];
            sz_r  <= sz;
`ifdef IBUS_UNALIGNED_EN
            we_r    <= we;
            wdata_r <= wdata;
`endif
            if (mis_s) begin
`ifdef IBUS_UNALIGNED_EN
              state_r <= SPLIT;
`else
              ack   <= 1'b1;
              err   <= 1'b1;
              rdata <= {DW{1'b0}};
`endif
            end else if (we) begin
              ack <= 1'b1;
            end else begin
              state_r <= RD_W;
            end
          end
        end
        RD_W: begin
          rdata   <= ext_s;
          ack     <= 1'b1;
          state_r <= IDLE;
        end
`ifdef IBUS_UNALIGNED_EN
        SPLIT: begin
          if (we_r) begin
            ack     <= 1'b1;
            state_r <= IDLE;
          end else begin
            lo_r    <= bus.vo;
            state_r <= RD_W2;
          end
        end
        RD_W2: begin
          rdata   <= ext_s;
          ack     <= 1'b1;
          state_r <= IDLE;
        end
`endif
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibus32_master.sv
// Randomized bench for ibus32_master against a byte-addressed memory model.
module tb_ibus32_master;

  localparam int AW = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sz = 2'd0;
  logic [16:0] addr = 17'd0;
  logic [31:0] wdata = 32'd0;
  logic        rdy, ack, err;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;

  ibus32_if bus ();

  ibus32_master #(.AW(AW), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rdy(rdy), .we(we), .sz(sz),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef IBUS_UNALIGNED_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  function automatic logic [31:0] pat(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  // Bus slave: 32K x 32 synchronous RAM with lane writes.
  logic [31:0] ram [0:32767];
  logic        ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int w = 0; w < 32768; w++) ram[w] <= pat(w);
    end else if (bus.we) begin
      for (int b = 0; b < 4; b++)
        if (bus.bmsk[b]) ram[bus.ai][8*b +: 8] <= bus.vi[8*b +: 8];
    end
    bus.vo <= ram[bus.ai];
  end

  // Reference: flat byte memory, wraps at 128 KiB.
  logic [7:0]  mdl [0:131071];
  logic [31:0] hold;

  function automatic logic [31:0] mdl_rd(input logic [16:0] a, input int nb);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[(int'(a) + i) % 131072];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic do_op(input logic op_we, input logic [1:0] op_sz, input logic [16:0] op_addr,
                       input logic [31:0] op_wd, output logic [31:0] got);
    int nb, off, lat, exp_lat;
    logic mis, exp_err, exp_we;
    logic [31:0] exp_rd;
    logic [3:0] eb1, eb2;
    nb  = (op_sz == 2'd0) ? 1 : (op_sz == 2'd1) ? 2 : 4;
    off = int'(op_addr[1:0]);
    mis = (off + nb > 4);
    eb1 = 4'h0;
    eb2 = 4'h0;
    for (int i = 0; i < nb; i++)
      if (off + i < 4) eb1[off+i] = 1'b1; else eb2[off+i-4] = 1'b1;
    if (mis && !SPLIT_ON) begin
      exp_lat = 1; exp_err = 1'b1; exp_rd = 32'h0; exp_we = 1'b0;
    end else if (op_we) begin
      exp_lat = mis ? 2 : 1; exp_err = 1'b0; exp_rd = hold; exp_we = 1'b1;
      for (int i = 0; i < nb; i++) mdl[(int'(op_addr) + i) % 131072] = op_wd[8*i +: 8];
    end else begin
      exp_lat = mis ? 3 : 2; exp_err = 1'b0; exp_rd = mdl_rd(op_addr, nb); exp_we = 1'b0;
    end
    hold = exp_rd;

    @(negedge clk);
    req = 1'b1; we = op_we; sz = op_sz; addr = op_addr; wdata = op_wd;
    #1;
    check("rdy_idle", {31'd0, rdy}, 32'd1);
    check("acc_we", {31'd0, bus.we}, {31'd0, exp_we});
    check("acc_bmsk", {28'd0, bus.bmsk}, exp_we ? {28'd0, eb1} : 32'd0);
    check("acc_ai", {17'd0, bus.ai}, {17'd0, op_addr[16:2]});
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && mis && SPLIT_ON && op_we) begin
        check("split_ai", {17'd0, bus.ai}, {17'd0, 15'(op_addr[16:2] + 15'd1)});
        check("split_we", {31'd0, bus.we}, 32'd1);
        check("split_bmsk", {28'd0, bus.bmsk}, {28'd0, eb2});
      end
    end while (!ack && lat < 8);
    got = rdata;
    check("latency", lat, exp_lat);
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("rdata", rdata, exp_rd);
    @(negedge clk);
    check("ack_once", {31'd0, ack}, 32'd0);
  endtask

  logic [31:0] got, tmp;

  initial begin
    for (int w = 0; w < 32768; w++) begin
      tmp = pat(w);
      for (int b = 0; b < 4; b++) mdl[4*w + b] = tmp[8*b +: 8];
    end
    hold = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bus_we", {31'd0, bus.we}, 32'd0);
    check("rst_bmsk", {28'd0, bus.bmsk}, 32'd0);
    ram_init = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", {31'd0, rdy}, 32'd1);

    do_op(1'b1, 2'd2, 17'h00010, 32'hDEADBEEF, got);
    do_op(1'b0, 2'd2, 17'h00010, 32'h0, got);
    check("word_load", got, 32'hDEADBEEF);

    // Back-to-back byte stores, one accepted per cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) check("b2b_ack", {31'd0, ack}, 32'd1);
      req = 1'b1; we = 1'b1; sz = 2'd0; addr = 17'h20 + 17'(i); wdata = 32'h11 * 32'(i + 1);
      mdl[32 + i] = 8'(8'h11 * (i + 1));
      #1;
      check("b2b_rdy", {31'd0, rdy}, 32'd1);
      check("b2b_bmsk", {28'd0, bus.bmsk}, 32'd1 << i);
    end
    @(negedge clk);
    check("b2b_ack_last", {31'd0, ack}, 32'd1);
    check("b2b_rdata_hold", rdata, hold);
    req = 1'b0;
    do_op(1'b0, 2'd2, 17'h00020, 32'h0, got);
    check("bytes_word", got, 32'h44332211);
    do_op(1'b0, 2'd0, 17'h00022, 32'h0, got);
    check("byte_22", got, 32'h00000033);

    do_op(1'b1, 2'd1, 17'h1FFFF, 32'h0000ABCD, got);
    do_op(1'b0, 2'd1, 17'h1FFFF, 32'h0, got);
    check("half_wrap", got, SPLIT_ON ? 32'h0000ABCD : 32'h0);
    do_op(1'b0, 2'd2, 17'h1FFFC, 32'h0, got);
    do_op(1'b0, 2'd2, 17'h00000, 32'h0, got);

    // req held through RD_W: second request waits for the ack cycle.
    @(negedge clk);
    req = 1'b1; we = 1'b0; sz = 2'd2; addr = 17'h40;
    @(negedge clk);
    check("held_rdy_busy", {31'd0, rdy}, 32'd0);
    addr = 17'h44;
    @(negedge clk);
    check("held_ack1", {31'd0, ack}, 32'd1);
    check("held_rdy_ack", {31'd0, rdy}, 32'd1);
    check("held_rd1", rdata, mdl_rd(17'h40, 4));
    @(negedge clk);
    check("held_single", {31'd0, ack}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    check("held_ack2", {31'd0, ack}, 32'd1);
    check("held_rd2", rdata, mdl_rd(17'h44, 4));
    hold = mdl_rd(17'h44, 4);
    @(negedge clk);

    // Reset in the middle of a multi-cycle load.
    @(negedge clk);
    req = 1'b1; we = 1'b0;
    if (SPLIT_ON) begin sz = 2'd1; addr = 17'h1FFFF; end
    else begin sz = 2'd2; addr = 17'h00010; end
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    if (SPLIT_ON) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_rdy", {31'd0, rdy}, 32'd1);
    check("mid_rst_we", {31'd0, bus.we}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_noack", {31'd0, ack}, 32'd0);
    end
    rst_n = 1'b1;
    hold = 32'h0;
    do_op(1'b0, 2'd2, 17'h00010, 32'h0, got);

    // Random traffic near the bottom and the wrap point of the address space.
    for (int k = 0; k < 150; k++) begin
      logic [16:0] ra;
      if ($urandom_range(0, 3) == 0) ra = 17'h1FFF0 + 17'($urandom_range(0, 15));
      else ra = 17'($urandom_range(0, 255));
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ibus32_master.md
Name: ibus32_master

Overview:
- Initiator end of the iBus32 memory bus. It converts CPU-side byte-addressed load/store requests (byte, half, word) into iBus32 word accesses with lane masks.
- It drives the word-organised 32K x 32 single-port RAM behind the bus and returns right-aligned, zero-extended read data with a one-cycle ack.
- It sits between the eForth core's load/store unit and the iBus32 memory slave.

Parameters:
- AW, 17, byte-address width; word index is AW-2 = 15 bits, matching bus.ai.
- DW, 32, data width; fixed at 32, kept for documentation only.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  request valid; qualified by rdy.
- rdy  output  1  ready; high only in IDLE.
- we  input  1  1 = store, 0 = load.
- sz  input  2  access size (mem_sz_t): BYTE=0, HALF=1, WORD=2; 3 is reserved and treated as WORD.
- addr  input  AW  byte address.
- wdata  input  32  store data, right-aligned.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  load data, zero-extended; valid while ack is high.
- err  output  1  misaligned-access flag; pulses with ack.
- bus  iBus32.master  -  drives we, bmsk, ai, vi; samples vo. A master modport is added to iBus32: outputs we, bmsk, ai, vi; input vo.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, ack=0, err=0, rdata=0, bus.we=0, bus.bmsk=0. bus.ai and bus.vi are don't-care but driven 0.
- Lane conventions:
  - Byte lane b = data[8b+7:8b] (little-endian within the word).
  - off = addr[1:0]; word index A = addr[AW-1:2].
  - Byte-enable pattern m = 1/3/15 for BYTE/HALF/WORD.
  - bmsk bit = 1 means that lane is written.
- Acceptance: at edge E0 when req && rdy. In IDLE, bus signals are driven combinationally from the request so the RAM samples A at E0: ai=A, we=we, bmsk=(m<<off)[3:0] when writing else 0, vi=wdata<<(8*off).
- Misalignment: HALF with off=3, or WORD with off≠0.
- States:
  - IDLE: rdy=1. Transitions on accept:
    - Aligned load -> RD_W.
    - Aligned store -> IDLE, with ack high in the cycle after E0.
    - Misaligned -> SPLIT (feature on) or ERR handling (feature off).
  - RD_W: bus we=0, ai held. At E1, rdata <= (vo>>(8*off)) & mask(sz); ack pulses in the cycle after E1 (2-cycle latency); -> IDLE.
  - SPLIT: issues the second access at ai=A+1. The index wraps 0x7FFF -> 0x0000.
    - Store: bmsk=(m<<off)[6:4] placed in lanes 0..2, vi=wdata>>(8*(4-off)); ack after E1; -> IDLE.
    - Load: we=0; vo(A) captured into a low buffer at E1; -> RD_W2.
  - RD_W2: at E2 captures vo(A+1), assembles rdata = ({vo(A+1),vo(A)}>>(8*off)) & mask; ack after E2 (3-cycle latency); -> IDLE.
- Outside IDLE: bus.we=1 only in the SPLIT store cycle; otherwise 0 with bmsk=0.
- ack/err timing: ack and err are registered and high exactly one cycle. rdy is high during the ack cycle, so back-to-back requests sustain one write per cycle.
- Request signals: req while rdy=0 is ignored (no queueing). The requester holds req until it sees rdy. addr/wdata are registered at accept and need not be held afterwards.
- Store ack: rdata is unchanged (holds its previous value) on a store ack.
- Reset mid-operation: rst_n low forces IDLE immediately and bus.we=0; any in-flight ack is dropped. A split store interrupted between halves leaves the first half written (documented, not repaired).

Optional Feature:
- IBUS_UNALIGNED_EN defined: misaligned accesses are split into two word accesses as described (SPLIT/RD_W2); err is never set.
- Not defined: SPLIT and RD_W2 are not built.
  - A misaligned request is accepted with no bus write (bus.we=0).
  - In the next cycle ack=1, err=1, rdata=0, and the state is IDLE.

Decomposition:
- Package ibus_pkg holds:
  - typedef enum logic [1:0] mem_sz_t {SZ_BYTE, SZ_HALF, SZ_WORD}.
  - typedef enum state_t {IDLE, RD_W, SPLIT, RD_W2}.
  - Function lane_mask(sz), returning 1/3/15.
  - Localparam WA = 15.
- One natural sub-module: ibus_lane_align. It is combinational and does the shift/mask/zero-extend for store-lane placement and load extraction, so it can be reused by a future byte-debug port.

Test Plan:
- Reset, then WORD store 0xDEADBEEF @0x00010, then WORD load @0x00010 -> bus.we=1 with bmsk=4'hF at accept; load ack 2 cycles after accept with rdata=0xDEADBEEF, err=0.
- BYTE stores 0x11,0x22,0x33,0x44 to @0x20..0x23 back-to-back -> bmsk 1,2,4,8 on consecutive cycles; WORD load @0x20 returns 0x44332211; BYTE load @0x22 returns 0x00000033.
- HALF store 0xABCD @0x1FFFF (word 0x7FFF, off 3) with feature on -> writes lane 3 of word 0x7FFF = 0xCD, then lane 0 of word 0x0000 = 0xAB (wrap); HALF load @0x1FFFF returns 0x0000ABCD with 3-cycle latency.
- Same request with feature off -> no bus write; ack=1, err=1, rdata=0 one cycle after accept; memory is unchanged.
- req held high during RD_W -> rdy=0 and the request is not accepted; it is accepted in the ack cycle (rdy=1), and ack pulses exactly once per request.
- rst_n asserted in RD_W2 -> outputs return to reset values asynchronously with no ack; the next load after release completes normally.
